// File: rtl/riscv16_pkg.sv
// Shared constants and types for the 16-bit core front end.
package riscv16_pkg;

    localparam int XLEN = 16;
    localparam int ILEN = 16;

    localparam logic [XLEN-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory and decode-side bus of the fetch unit.
// master = fetch unit, slave = memory/decoder environment.
interface ifetch_unit_if;
    import riscv16_pkg::*;

    // All channels: a transfer happens in a cycle where valid && ready are
    // both high; valid never depends on ready. Responses have no ready.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [ILEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
    );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push and pop may coincide.
module fetch_fifo
    import riscv16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fetch_entry_t           entry_i,
    output fetch_entry_t           entry_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push) wr_d = wr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= entry_i;
    end

    assign entry_o = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch unit: owns the fetch PC, issues credit-limited imem requests, buffers
// responses for decode and flushes on redirect. Option: IFETCH_BYPASS_EN.
module ifetch_unit
    import riscv16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_pc,
    ifetch_unit_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
    logic            rst_q;

    logic [CW-1:0] buf_count, pcq_count;
    fetch_entry_t  buf_head, pcq_head, pcq_entry, rsp_entry;
    logic          req_fire, rsp_keep, dec_fire, buf_empty, buf_push, buf_pop;
    logic          pcq_unused;

    assign bus.imem_req_valid = !rst && !rst_q && !redirect_valid &&
                                (({1'b0, out_q} + {1'b0, buf_count}) < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign fetch_pc           = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Responses owed to pre-redirect requests, or landing in the redirect
    // cycle itself, never reach the buffer.
    assign rsp_keep  = bus.imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign buf_empty = (buf_count == '0);
    assign pcq_entry = '{instr: '0, pc: fetch_pc_q};
    assign rsp_entry = '{instr: bus.imem_rsp_data, pc: pcq_head.pc};
    assign pcq_unused = ^{pcq_head.instr, pcq_count};

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    assign bypass        = rsp_keep && buf_empty;
    assign bus.dec_valid = !rst && (!buf_empty || bypass);
    assign bus.dec_instr = buf_empty ? rsp_entry.instr : buf_head.instr;
    assign bus.dec_pc    = buf_empty ? rsp_entry.pc : buf_head.pc;
    assign buf_push      = rsp_keep && !(bypass && bus.dec_ready);
`else
    assign bus.dec_valid = !rst && !buf_empty;
    assign bus.dec_instr = buf_head.instr;
    assign bus.dec_pc    = buf_head.pc;
    assign buf_push      = rsp_keep;
`endif

    assign dec_fire = bus.dec_valid && bus.dec_ready;
    assign buf_pop  = dec_fire && !buf_empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + {{(CW-1){1'b0}}, req_fire}
                           - {{(CW-1){1'b0}}, bus.imem_rsp_valid};
        drop_d     = drop_q;
        if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(1);
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_d     = out_d;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .pop_i   (rsp_keep),
        .entry_i (pcq_entry),
        .entry_o (pcq_head),
        .count_o (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .entry_i (rsp_entry),
        .entry_o (buf_head),
        .count_o (buf_count)
    );

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Consumer side of the program counter: owns the fetch PC, issues word-addressed requests to instruction memory, buffers in-order responses, and presents instruction and PC to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush buffered and in-flight fetches.
- Sits between the PC/branch logic and the decoder in the 16-bit core.

Parameters:
- XLEN, 16, address and PC width; PC is a word address, sequential step is +1.
- ILEN, 16, instruction width.
- DEPTH, 2, fetch buffer entries; also the maximum number of outstanding plus buffered fetches; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  load new fetch PC and flush.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word address of the request.
- imem_rsp_valid  in  1  response valid; responses return in order, latency of 1 or more cycles; there is no ready, the unit must always accept.
- imem_rsp_data  in  ILEN  instruction word.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode accepts.
- dec_instr  out  ILEN  instruction.
- dec_pc  out  XLEN  PC of dec_instr.
- fetch_pc  out  XLEN  current fetch PC.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=0x0000; buffer empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0 and dec_valid=0 in the reset cycle and the following cycle.
  - dec_instr and dec_pc are don't-care while dec_valid=0.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + count < DEPTH).
  - This guarantees buffer space for every response.
- Request:
  - imem_req_addr = fetch_pc.
  - When imem_req_valid && imem_req_ready:
    - outstanding += 1;
    - a request-PC queue (depth DEPTH) records fetch_pc;
    - fetch_pc += 1, wrapping 0xFFFF -> 0x0000.
  - Once asserted, imem_req_valid stays high until accepted; it drops without acceptance only on redirect.
- Response:
  - If drop_cnt > 0: the response is discarded, drop_cnt -= 1, outstanding -= 1.
  - Otherwise: {data, queued PC} is pushed to the buffer and outstanding -= 1.
  - Response latency into the buffer is 1 cycle (without the optional feature).
- Decode:
  - dec_valid = buffer non-empty.
  - A pop occurs on dec_valid && dec_ready.
  - dec_instr and dec_pc hold stable while dec_valid && !dec_ready.
- Redirect, in the cycle redirect_valid=1:
  - No request is issued.
  - A decode handshake in the same cycle still completes (it counts as consumed).
  - At the clock edge: buffer and PC queue are cleared; fetch_pc=redirect_pc; drop_cnt=outstanding after that cycle's response is accounted for; outstanding is unchanged.
  - A response arriving in the redirect cycle is discarded.
  - dec_valid=0 in the next cycle.
  - A new request may issue in the next cycle, within credit.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Full condition: outstanding + count == DEPTH → imem_req_valid=0.
- Reset mid-operation: all in-flight responses are forgotten. Memory is reset by the same rst.

Optional Feature:
- IFETCH_BYPASS_EN:
  - Defined: when the buffer is empty and a non-dropped response arrives, dec_valid=1 in the same cycle with dec_instr=imem_rsp_data (zero-latency forward). The entry is pushed only if !dec_ready. dec_pc comes from the PC-queue head.
  - Undefined: responses always pass through the buffer, giving 1 cycle of latency.

Decomposition:
- Package riscv16_pkg:
  - XLEN/ILEN constants;
  - typedef fetch_entry_t {instr, pc};
  - constant RESET_PC=16'h0000.
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch_entry_t;
  - push/pop/flush/count; DEPTH parameter;
  - simultaneous push and pop allowed when full or empty.
- Instantiated twice: data buffer, and PC queue (data field unused).

Test Plan:
- Reset release, memory always ready, latency 1 → requests to 0x0000, 0x0001, 0x0002…; dec_pc follows the same sequence; dec_valid first rises 3 cycles after reset deasserts (2 with IFETCH_BYPASS_EN).
- dec_ready=0 held → exactly DEPTH=2 requests issued, then imem_req_valid=0; dec_instr stable; releasing dec_ready resumes fetch at 0x0002.
- Redirect to 0x0100 with 2 requests outstanding at latency 3 → both late responses dropped; next dec_pc=0x0100; no stale instruction reaches decode.
- Redirect to 0xFFFF → dec_pc sequence 0xFFFF, 0x0000, 0x0001.
- Redirect coinciding with a decode handshake and a response → handshake completes, response dropped; dec_valid=0 in the next cycle.
- rst asserted with 2 outstanding and 1 buffered → dec_valid=0; after release, fetch restarts at 0x0000 and stale responses are never presented.
